// File: rtl/btn_if.sv
// Button conditioner signal bundle: raw buttons and enable in, clean
// levels and command pulses out.
interface btn_if #(
  parameter int N_BTN = 4
);
  logic             enable;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic             any_pulse;

  // Source of button levels and the mode gate (board / testbench side).
  modport master (
    output enable,
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  any_pulse
  );

  // The conditioner itself.
  modport slave (
    input  enable,
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output any_pulse
  );
endinterface

// File: rtl/btn_conditioner.sv
// Button conditioner: per-channel 2-FF synchronizer, counter debounce,
// press pulse and optional auto-repeat on hold, gated by a global enable.
module btn_conditioner #(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               HOLD_CYCLES     = 50_000_000,
  parameter int               REPEAT_CYCLES   = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0110,
  parameter int               CNT_W           = 27
) (
  input  logic   clk,
  input  logic   reset,
  btn_if.slave   bus
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [N_BTN-1:0] level_s;       // debounced levels gathered from channels
  logic [N_BTN-1:0] pulse_gated_s; // next-cycle pulses after the enable gate
  logic [N_BTN-1:0] pulse_r;
  logic             any_r;

  genvar g;
  generate
    for (g = 0; g < N_BTN; g++) begin : g_ch
      localparam bit REP_EN = REPEAT_MASK[g];

      logic             sync1_r;
      logic             sync2_r;
      logic             lvl_r;
      logic [CNT_W-1:0] db_cnt_r;
      logic             differ_s;
      logic             accept_s;
      logic             lvl_next_s;

      state_t           state_r;
      state_t           state_s;
      logic [CNT_W-1:0] tm_cnt_r;
      logic [CNT_W-1:0] tm_cnt_s;
      logic             pulse_s;

      // The FSM acts on the level the debouncer is about to register, so a
      // press pulse lands on the same edge as the btn_level rise and a
      // release is seen on the edge btn_level falls.
      assign differ_s   = (sync2_r != lvl_r);
      assign accept_s   = differ_s && (db_cnt_r == DB_LAST);
      assign lvl_next_s = accept_s ? sync2_r : lvl_r;

      // Synchronize the raw level and debounce it with a stable-run counter.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_r  <= 1'b0;
          sync2_r  <= 1'b0;
          lvl_r    <= 1'b0;
          db_cnt_r <= '0;
        end else begin
          sync1_r <= bus.btn_raw[g];
          sync2_r <= sync1_r;
          lvl_r   <= lvl_next_s;
          if (!differ_s || accept_s) begin
            db_cnt_r <= '0;
          end else begin
            db_cnt_r <= db_cnt_r + CNT_ONE;
          end
        end
      end

      // Next state, hold/repeat counter and pulse request for this channel.
      always_comb begin
        state_s  = state_r;
        tm_cnt_s = tm_cnt_r;
        pulse_s  = 1'b0;
        if (!bus.enable) begin
          state_s  = ST_IDLE;
          tm_cnt_s = '0;
        end else begin
          case (state_r)
            ST_IDLE: begin
              if (accept_s && sync2_r) begin
                pulse_s  = 1'b1;
                state_s  = ST_HOLD;
                tm_cnt_s = '0;
              end else begin
                tm_cnt_s = '0;
              end
            end
            ST_HOLD: begin
              if (!lvl_next_s) begin
                state_s  = ST_IDLE;
                tm_cnt_s = '0;
              end else if (REP_EN && (tm_cnt_r == HOLD_LAST)) begin
                pulse_s  = 1'b1;
                state_s  = ST_REPEAT;
                tm_cnt_s = '0;
              end else if (tm_cnt_r != HOLD_LAST) begin
                tm_cnt_s = tm_cnt_r + CNT_ONE;
              end else begin
                tm_cnt_s = tm_cnt_r;  // non-repeat channel: saturate
              end
            end
            ST_REPEAT: begin
              if (!lvl_next_s) begin
                state_s  = ST_IDLE;
                tm_cnt_s = '0;
              end else if (tm_cnt_r == REP_LAST) begin
                pulse_s  = 1'b1;
                tm_cnt_s = '0;
              end else begin
                tm_cnt_s = tm_cnt_r + CNT_ONE;
              end
            end
            default: begin
              state_s  = ST_IDLE;
              tm_cnt_s = '0;
            end
          endcase
        end
      end

      // Channel FSM state and hold/repeat counter registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_r  <= ST_IDLE;
          tm_cnt_r <= '0;
        end else begin
          state_r  <= state_s;
          tm_cnt_r <= tm_cnt_s;
        end
      end

      assign level_s[g]       = lvl_r;
      assign pulse_gated_s[g] = pulse_s & bus.enable;
    end
  endgenerate

  // Output pulse register; any_pulse is registered alongside btn_pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_r <= '0;
      any_r   <= 1'b0;
    end else begin
      pulse_r <= pulse_gated_s;
      any_r   <= |pulse_gated_s;
    end
  end

  assign bus.btn_level = level_s;
  assign bus.btn_pulse = pulse_r;
  assign bus.any_pulse = any_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random
// bouncy stimulus, every cycle compared against a window-based reference.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clk;
  logic reset;

  btn_if #(.N_BTN(4)) bus ();

  btn_conditioner #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .REPEAT_MASK    (4'b0110),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  bit [3:0] mask = 4'b0110;
  bit       samp [4][6];   // samp[i][j] = raw sampled j+1 edges ago
  bit [3:0] m_lvl;
  bit [3:0] m_act;
  int       since [4];
  bit [3:0] m_pulse;

  // observation counters
  int pcnt   [4];
  int pfirst [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Level accepted when the last D synchronized samples agree and differ
  // from the current level; pulses derived from time since the press.
  task automatic model_edge();
    bit v, all, nl, rose;
    m_pulse = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        m_lvl[i] = 1'b0;
        m_act[i] = 1'b0;
      end else begin
        v   = samp[i][1];
        all = 1'b1;
        for (int j = 1; j <= D; j++) if (samp[i][j] != v) all = 1'b0;
        nl   = (all && (v != m_lvl[i])) ? v : m_lvl[i];
        rose = nl && !m_lvl[i];
        if (!bus.enable) begin
          m_act[i] = 1'b0;
        end else if (rose) begin
          m_pulse[i] = 1'b1;
          m_act[i]   = 1'b1;
          since[i]   = 0;
        end else if (m_act[i]) begin
          if (!nl) begin
            m_act[i] = 1'b0;
          end else begin
            since[i]++;
            if (mask[i] && since[i] >= H && ((since[i] - H) % R) == 0) m_pulse[i] = 1'b1;
          end
        end
        m_lvl[i] = nl;
      end
      for (int j = 5; j > 0; j--) samp[i][j] = samp[i][j-1];
      samp[i][0] = reset ? 1'b0 : bus.btn_raw[i];
      if (reset) samp[i][1] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    check_eq("level", 32'(bus.btn_level), 32'(m_lvl));
    check_eq("pulse", 32'(bus.btn_pulse), 32'(m_pulse));
    check_eq("any",   32'(bus.any_pulse), 32'(|m_pulse));
    for (int i = 0; i < 4; i++) begin
      if (bus.btn_pulse[i] === 1'b1) begin
        if (pcnt[i] == 0) pfirst[i] = cyc;
        pcnt[i]++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      pcnt[i]   = 0;
      pfirst[i] = 0;
    end
  endtask

  int s;
  logic [3:0] r;
  int div;

  initial begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 6; j++) samp[i][j] = 1'b0;
      since[i] = 0;
    end
    m_lvl = 4'b0000;
    m_act = 4'b0000;
    reset = 1'b1;
    bus.enable  = 1'b1;
    bus.btn_raw = 4'b0000;
    run(3);
    check_eq("reset_out", {bus.btn_level, bus.btn_pulse, 3'b000, bus.any_pulse}, 32'd0);
    reset = 1'b0;
    run(4);

    // 1. clean press on C: one pulse at edge 6, no repeat
    clr(); s = cyc;
    bus.btn_raw = 4'b0001;
    run(100);
    check_eq("s1_first", 32'(pfirst[0] - s), 32'd6);
    check_eq("s1_count", 32'(pcnt[0]), 32'd1);
    bus.btn_raw = 4'b0000;
    run(10);

    // 2. bounce on R, then steady high
    clr();
    for (int k = 0; k < 40; k++) begin
      bus.btn_raw[2] = ((k % 4) != 3);
      tick();
    end
    check_eq("s2_bounce", 32'(pcnt[2]), 32'd0);
    clr(); s = cyc;
    bus.btn_raw[2] = 1'b1;
    run(12);
    check_eq("s2_first", 32'(pfirst[2] - s), 32'd6);
    bus.btn_raw = 4'b0000;
    run(10);

    // 3. auto-repeat on L: P, P+20, P+28 ... P+52 within P+59
    clr(); s = cyc;
    bus.btn_raw[1] = 1'b1;
    run(65);
    check_eq("s3_first", 32'(pfirst[1] - s), 32'd6);
    check_eq("s3_count", 32'(pcnt[1]), 32'd6);
    clr();
    bus.btn_raw[1] = 1'b0;
    run(12);
    check_eq("s3_release", 32'(pcnt[1]), 32'd1);
    check_eq("s3_level", 32'(bus.btn_level[1]), 32'd0);

    // 4. release collides with hold expiry on L and R
    clr();
    bus.btn_raw = 4'b0110;
    run(20);
    bus.btn_raw = 4'b0000;
    run(12);
    check_eq("s4_l", 32'(pcnt[1]), 32'd1);
    check_eq("s4_r", 32'(pcnt[2]), 32'd1);

    // 5. enable gating
    clr();
    bus.enable = 1'b0;
    bus.btn_raw[1] = 1'b1;
    run(50);
    bus.enable = 1'b1;
    run(10);
    check_eq("s5_level", 32'(bus.btn_level[1]), 32'd1);
    check_eq("s5_none", 32'(pcnt[1]), 32'd0);
    bus.btn_raw[1] = 1'b0;
    run(10);
    clr(); s = cyc;
    bus.btn_raw[1] = 1'b1;
    run(10);
    check_eq("s5_resume", 32'(pfirst[1] - s), 32'd6);
    bus.btn_raw = 4'b0000;
    run(10);

    // 6. reset mid-repeat, then C+U together
    bus.btn_raw[1] = 1'b1;
    run(35);
    reset = 1'b1;
    tick();
    check_eq("s6_rst", {bus.btn_level, bus.btn_pulse, 3'b000, bus.any_pulse}, 32'd0);
    reset = 1'b0;
    clr(); s = cyc;
    run(10);
    check_eq("s6_repress", 32'(pfirst[1] - s), 32'd6);
    bus.btn_raw = 4'b0000;
    run(10);
    clr(); s = cyc;
    bus.btn_raw = 4'b1001;
    run(10);
    check_eq("s6_c", 32'(pfirst[0] - s), 32'd6);
    check_eq("s6_u", 32'(pfirst[3] - s), 32'd6);
    bus.btn_raw = 4'b0000;
    run(10);

    // random bouncy then slow stimulus with occasional enable/reset events
    r = 4'b0000;
    for (int k = 0; k < 4000; k++) begin
      div = (k < 1500) ? 3 : 40;
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, div - 1) == 0) r[i] = ~r[i];
      end
      bus.btn_raw = r;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
